// File: rtl/uart_tx_fifo_core_if.sv
// Write channel between the register slice and the UART TX FIFO.
interface uart_tx_fifo_core_if #(
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo_core.sv
// UART transmitter with integrated TX FIFO: runtime character length,
// none/even/odd parity, 1/2 stop bits, back-to-back framing.
module uart_tx_fifo_core #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [3:0]                  cfg_dbits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic                        tx_en,
    uart_tx_fifo_core_if.slave          wr,
    output logic                        txd,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // Configuration captured when a frame starts; held for the whole frame.
    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [3:0]       dbits;
        logic [1:0]       parity;
        logic             stop2;
    } frame_cfg_t;

    // ---------------- FIFO ----------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              push, pop;

    // No bypass: a full FIFO refuses writes even when a pop is under way.
    assign wr.wr_ready = !rst && (level_q != LW'(FIFO_DEPTH));
    assign push        = wr.wr_valid && wr.wr_ready;
    assign fifo_level  = level_q;

    // Storage array; contents need no reset since level_q guards reads.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr.wr_data;
    end

    // Pointers wrap naturally (power-of-2 depth); level tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: ;
            endcase
        end
    end

    // Head entry masked to the requested width, so upper bits never reach
    // the line or the parity calculation.
    logic [DATA_W-1:0] head, mask;
    logic [3:0]        dbits_eff;

    // Clamp illegal character lengths to DATA_W and build the data mask.
    always_comb begin
        dbits_eff = (cfg_dbits >= 4'd5 && cfg_dbits <= 4'(DATA_W)) ? cfg_dbits : 4'(DATA_W);
        mask = '0;
        for (int i = 0; i < DATA_W; i++) mask[i] = (i < int'(dbits_eff));
        head = mem[rd_ptr_q] & mask;
    end

    // ---------------- Transmit FSM ----------------
    state_t            state_q, state_d;
    frame_cfg_t        cfg_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [3:0]        bidx_q;
    logic              stop_q;
    logic              txd_q, busy_q, done_q;
    logic              txd_d, busy_d, done_d;
    logic              tick, bit_adv, stop_adv, par_en, par_bit, have_data;

    assign par_en    = (cfg_q.parity == 2'b01) || (cfg_q.parity == 2'b10);
    assign par_bit   = par_q ^ (cfg_q.parity == 2'b10);
    assign have_data = tx_en && (level_q != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and next (registered) line outputs.
    always_comb begin
        state_d  = state_q;
        txd_d    = txd_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        bit_adv  = 1'b0;
        stop_adv = 1'b0;
        tick     = (cnt_q == cfg_q.div);
        case (state_q)
            IDLE: begin
                if (have_data) begin
                    state_d = START;
                    pop     = 1'b1;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bidx_q == cfg_q.dbits - 4'd1) begin
                        state_d = par_en ? PARITY : STOP;
                        txd_d   = par_en ? par_bit : 1'b1;
                    end else begin
                        bit_adv = 1'b1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_q == cfg_q.stop2) begin
                        done_d = 1'b1;
                        // Chain straight into the next start bit when possible.
                        if (have_data) begin
                            state_d = START;
                            pop     = 1'b1;
                            txd_d   = 1'b0;
                        end else begin
                            state_d = IDLE;
                            txd_d   = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stop_adv = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Frame datapath: bit timer, shifter, frame config and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            bidx_q  <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            cfg_q   <= '0;
        end else begin
            txd_q  <= txd_d;
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= (state_q == IDLE || tick) ? '0 : cnt_q + DIV_W'(1);
            if (pop) begin
                shift_q <= head;
                par_q   <= ^head;
                bidx_q  <= '0;
                stop_q  <= 1'b0;
                cfg_q   <= '{div: cfg_div, dbits: dbits_eff, parity: cfg_parity, stop2: cfg_stop2};
            end else begin
                if (bit_adv) begin
                    shift_q <= shift_q >> 1;
                    bidx_q  <= bidx_q + 4'd1;
                end
                if (stop_adv) stop_q <= 1'b1;
            end
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
endmodule

// File: doc/uart_tx_fifo_core.md
Name: uart_tx_fifo_core

Overview:
- Parametrised UART transmit engine with an integrated TX FIFO.
- Successor to the fixed 8-bit, even/no-parity transmitter in gjy_uart_top.
- Adds runtime-selectable character length (5..DATA_W), none/even/odd parity, 1 or 2 stop bits, and back-to-back framing from a FIFO_DEPTH-entry buffer.
- Sits between the ICB register slice (which drives cfg_* and the write channel) and the txd pad.

Parameters:
- DATA_W, 8: maximum character width in bits (5..9).
- FIFO_DEPTH, 16: TX FIFO entries; power of 2, at least 2.
- DIV_W, 16: baud divisor width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cfg_div  in  DIV_W  bit period = cfg_div+1 clk cycles.
- cfg_dbits  in  4  data bits per character. Legal 5..DATA_W; any other value is treated as DATA_W.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none.
- cfg_stop2  in  1  0: one stop bit, 1: two stop bits.
- tx_en  in  1  transmit enable.
- wr_valid  in  1  write request.
- wr_ready  out  1  FIFO can accept.
- wr_data  in  DATA_W  character, LSB-aligned.
- txd  out  1  serial output, idle high.
- busy  out  1  FSM not IDLE.
- tx_done  out  1  one-cycle pulse at the end of each frame.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset:
  - Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
  - While rst=1: txd=1, busy=0, tx_done=0, fifo_level=0, wr_ready=0. FIFO pointers are cleared and the FSM goes to IDLE.
  - Reset mid-frame aborts the frame. txd=1 from the first edge with rst sampled high.
- FIFO and write handshake:
  - wr_ready = !rst && (fifo_level != FIFO_DEPTH), driven from registered state.
  - A push occurs on an edge where wr_valid && wr_ready.
  - There is no bypass. When full, wr_ready stays low even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE -> START:
  - Taken when tx_en=1 and fifo_level != 0.
  - On that edge: pop the FIFO head into the shift register, set txd=0, busy=1.
  - Latch cfg_div, cfg_dbits, cfg_parity and cfg_stop2 into frame-local registers. Config changes mid-frame take effect at the next frame.
- Bit timing:
  - A bit counter runs 0..div and each bit lasts div+1 cycles. cfg_div=0 gives 1 cycle per bit.
- Latency: a push into an empty FIFO while in IDLE with tx_en=1 drives txd low exactly 1 cycle after the accepting edge.
- START -> DATA: the data bits are sent LSB first, for dbits bits. wr_data bits above dbits are ignored.
- DATA -> PARITY or STOP:
  - Goes to PARITY if parity is enabled, else STOP.
  - Parity bit: even = XOR of the transmitted bits; odd = its inverse.
- STOP: txd=1 for 1 or 2 bit periods.
- End of the last stop bit:
  - tx_done pulses high for one cycle.
  - If tx_en=1 and the FIFO is not empty, go directly to START with a new pop. There is no idle gap, so busy stays 1.
  - Otherwise go to IDLE with busy=0.
- tx_en deasserted mid-frame: the current frame completes and the next one does not start. The FIFO contents are retained.
- Frame length in cycles = (1 + dbits + (parity?1:0) + (stop2?2:1)) * (div+1).

Test Plan:
- Reset: hold rst=1 for 3 cycles with wr_valid=1 -> txd=1, busy=0, fifo_level=0, wr_ready=0 throughout, no push. wr_ready=1 on the first cycle after release.
- 8N1, div=3, write 0xA5 with tx_en=1:
  - txd falls 1 cycle after accept.
  - Sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - tx_done pulses 40 cycles after txd falls, then busy=0.
- 7E2, div=1, write 0x83:
  - Bits sent 1,1,0,0,0,0,0 (bit 7 ignored), parity 0, two stop bits.
  - Frame = 11 bits x 2 = 22 cycles.
- 5-bit odd vs even, div=0, data 0x1F: odd parity bit = 0, even parity bit = 1. Frame = 8 cycles.
- FIFO_DEPTH=4, tx_en=0, write 0x11,0x22,0x33,0x44,0x55:
  - First 4 accepted; then wr_ready=0 and fifo_level=4.
  - Raise tx_en -> 4 back-to-back frames; the start bit of each follows the previous stop with no gap.
  - 4 tx_done pulses, fifo_level steps 3,2,1,0.
- Mid-frame events, div=7:
  - Drop tx_en during DATA -> frame completes and the next queued byte stays queued (fifo_level unchanged).
  - Change cfg_dbits during a frame -> it applies to the next frame only.
  - Assert rst during PARITY -> txd=1 next edge, busy=0, fifo_level=0.
